mx_fp32_stim_gen: RTL and testbench
===================================

// Module: mx_fp32_stim_gen
// PURPOSE
//  Synthesizable, parametrised FP32 stimulus source for the MXINT8 block converter; replaces sim-only drivers for FPGA/emulation runs.
//  Emits LANES FP32 words per beat, grouped into MX blocks of BLOCK_SIZE elements, sweeping enabled corner-case modes via a mode FSM.
//  Output is valid/ready streamed straight into the converter input; deterministic from LFSR_SEED.
// PARAMETERS
//  LANES           4             FP32 elements per beat; must divide BLOCK_SIZE
//  BLOCK_SIZE      32            elements per MX block (shared scale)
//  BLOCKS_PER_MODE 3             blocks emitted per enabled mode
//  LFSR_SEED       32'hACE12468  LFSR reset/start value; 0 is replaced by 1
// PORTS
//  clk          in   1          clock
//  rst          in   1          async active-high reset
//  start_i      in   1          begin sweep; sampled only in IDLE
//  mode_mask_i  in   8          bit m enables mode m; sampled with start_i
//  ready_i      in   1          downstream accepts beat
//  valid_o      out  1          data_o holds a beat
//  data_o       out  32*LANES   lane k = data_o[32k+:32], FP32 {sign,exp[7:0],mant[22:0]}
//  last_o       out  1          beat is final beat of an MX block
//  mode_o       out  3          mode of current beat
//  busy_o       out  1          FSM not IDLE
//  done_o       out  1          one-cycle pulse at sweep end
// BEHAVIOUR
//  Reset (async): FSM=IDLE, LFSR=seed, all outputs 0.
//  FSM: IDLE -start_i-> SEL (find lowest enabled mode >= cur) -> GEN -> SEL ... -> DONE -> IDLE. DONE lasts 1 cycle, drives done_o=1.
//  Latency: start_i high in IDLE -> valid_o=1 two cycles later (SEL, then GEN). mask=0 -> SEL->DONE, no beats.
//  start_i while busy_o=1 ignored. mode_mask latched at start; later changes ignored.
//  Handshake: beat accepted when valid_o&ready_i. While valid_o&!ready_i, data_o/last_o/mode_o stable, LFSR frozen.
//  LFSR: 32-bit Galois, taps 32'h80200003, advances once per accepted beat. Lane k random word r_k = rotl(lfsr, 5k).
//  Counters: beat index 0..BLOCK_SIZE/LANES-1, block index b 0..BLOCKS_PER_MODE-1; last_o=1 on final beat; wrap moves to SEL.
//  Sign = b[0] (even block +, odd block -) for every mode.
//  Exponent clamp E(r) = r[30:23] mapped 0->1, 255->254.
//  Modes (m: element rule, r=r_k):
//   0 NORMAL    exp=E(r), mant=r[22:0]
//   1 CARRY     exp=E(r), mant[22:16]=7'h7F, mant[15]=1, mant[14:0]=r[14:0]
//   2 TIE       exp=E(r), mant[22:16]=r[22:16], mant[15:0]=16'h8000
//   3 MANT_OVF  exp=Eb (per-block value, 1..253, latched at block start), mant[22:15]=8'hFF, rest r
//   4 SCALE_OVF exp=8'hFE, mant=23'h7FFFFF
//   5 NAN       as NORMAL, except lane (r_0[1:0] mod LANES) of beat 0 of each block: exp=8'hFF, mant=23'h400000|r[21:0]
//   6 SUBNORM   exp=0, mant=r[22:0]|23'h1
//   7 ZERO      exp=0, mant=0
//  rst mid-sweep: immediate return to IDLE; next start replays from seed bit-exact.
// CONFIGURATION
//  MX_STIM_CHECKSUM_EN defined: extra port checksum_o out 32 = XOR of all accepted lane words, cleared at start, held after DONE.
//  Undefined: no checksum_o port, no checksum logic.
// STRUCTURE
//  Package mx_stim_pkg: mode enum (8 codes), FSM state enum, FP32 field constants (FLOAT32_WIDTH, EXP/MANT widths, EXP_MAX=8'hFE, NAN_EXP=8'hFF), LFSR taps.
//  Sub-module mx_stim_lfsr: seeded Galois LFSR with advance enable.
// TESTING
//  mask=8'h80, defaults -> 24 beats, words 0x00000000 (blocks 0,2) / 0x80000000 (block 1), last_o on beats 8,16,24, done_o 1 cycle later.
//  mask=8'h10 -> 24 beats, all lanes 0x7F7FFFFF then 0xFF7FFFFF then 0x7F7FFFFF per block.
//  mask=8'h04 -> every word [15:0]=16'h8000, exp in 1..254; mode_o=2 throughout.
//  ready_i low 5 cycles mid-block -> outputs stable; full sequence identical to run with ready_i=1.
//  rst pulse during GEN -> valid_o,busy_o=0 at once; restart with mask=8'hFF reproduces golden 192-beat stream.
//  mask=8'h00 -> done_o pulse 2 cycles after start, valid_o never high; start while busy ignored.

Source files
------------

// File: rtl/mx_stim_pkg.sv
// Shared types, FP32 field constants and small helpers for the MX FP32 stimulus generator.
package mx_stim_pkg;

  localparam int unsigned FLOAT32_WIDTH = 32;
  localparam int unsigned EXP_WIDTH     = 8;
  localparam int unsigned MANT_WIDTH    = 23;
  localparam logic [7:0]  EXP_MAX       = 8'hFE;
  localparam logic [7:0]  NAN_EXP       = 8'hFF;
  localparam logic [31:0] LFSR_TAPS     = 32'h80200003;

  typedef enum logic [2:0] {
    MODE_NORMAL    = 3'd0,
    MODE_CARRY     = 3'd1,
    MODE_TIE       = 3'd2,
    MODE_MANT_OVF  = 3'd3,
    MODE_SCALE_OVF = 3'd4,
    MODE_NAN       = 3'd5,
    MODE_SUBNORM   = 3'd6,
    MODE_ZERO      = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_GEN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH-1:0] mant;
  } fp32_t;

  // Right-shifting Galois step: feedback bit is the LSB shifted out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] sh);
    return (x << sh) | (x >> (6'd32 - {1'b0, sh}));
  endfunction

  function automatic logic [7:0] exp_clamp(input logic [7:0] e);
    return (e == 8'd0) ? 8'd1 : ((e == NAN_EXP) ? EXP_MAX : e);
  endfunction

  // Per-block exponent for MANT_OVF, kept one below EXP_MAX so a mantissa carry still fits.
  function automatic logic [7:0] block_exp(input logic [7:0] e);
    return (e == 8'd0) ? 8'd1 : ((e > 8'd253) ? 8'd253 : e);
  endfunction

endpackage

// File: rtl/mx_stim_lfsr.sv
// Seeded 32-bit Galois LFSR with reload and advance enable; a zero seed is replaced by 1.
module mx_stim_lfsr
  import mx_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [31:0] lfsr_o
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)     lfsr_d = SEED_EFF;
    else if (adv_i) lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED_EFF;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mx_fp32_stim_gen.sv
// FP32 corner-case stimulus source for the MXINT8 converter, sweeping enabled modes block by block.
// Optional MX_STIM_CHECKSUM_EN adds checksum_o, the XOR of every accepted lane word since start.
module mx_fp32_stim_gen
  import mx_stim_pkg::*;
#(
  parameter int unsigned LANES           = 4,
  parameter int unsigned BLOCK_SIZE      = 32,
  parameter int unsigned BLOCKS_PER_MODE = 3,
  parameter logic [31:0] LFSR_SEED       = 32'hACE12468
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [7:0]                     mode_mask_i,
  input  logic                           ready_i,
  output logic                           valid_o,
  output logic [FLOAT32_WIDTH*LANES-1:0] data_o,
  output logic                           last_o,
  output logic [2:0]                     mode_o,
  output logic                           busy_o,
  output logic                           done_o
`ifdef MX_STIM_CHECKSUM_EN
  ,
  output logic [31:0]                    checksum_o
`endif
);

  localparam int unsigned DATA_W = FLOAT32_WIDTH * LANES;
  localparam int unsigned BEATS  = BLOCK_SIZE / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BLK_W  = (BLOCKS_PER_MODE > 1) ? $clog2(BLOCKS_PER_MODE) : 1;

  state_e              state_q;
  mode_e               mode_q;
  logic [7:0]          mask_q;
  logic [3:0]          cur_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [BLK_W-1:0]    blk_q;
  logic [7:0]          eb_q;
  logic                valid_q, last_q, busy_q, done_q;
  logic [DATA_W-1:0]   data_q;
  logic [31:0]         lfsr_q, lfsr_nxt;

  logic                accept_c, load_c, sel_found_c, last_beat_c, last_blk_c;
  mode_e               sel_mode_c;
  logic [BEAT_W-1:0]   beat_n_c;
  logic [BLK_W-1:0]    blk_n_c;
  logic [7:0]          eb_n_c;
  logic [DATA_W-1:0]   data_n_c, first_c;

  // One beat of lane words derived from a single LFSR state.
  function automatic logic [DATA_W-1:0] beat_word(input logic [31:0] s, input mode_e m,
                                                  input logic neg, input logic first,
                                                  input logic [7:0] eb);
    logic [DATA_W-1:0] w;
    logic [31:0]       r;
    fp32_t             f;
    int                nan_lane;
    w        = '0;
    nan_lane = int'(s[1:0]) % int'(LANES);
    for (int k = 0; k < int'(LANES); k++) begin
      r      = rotl32(s, 5'(5 * k));
      f      = fp32_t'(r);
      f.sign = neg;
      f.exp  = exp_clamp(r[30:23]);
      case (m)
        MODE_CARRY:     f.mant = {8'hFF, r[14:0]};
        MODE_TIE:       f.mant = {r[22:16], 16'h8000};
        MODE_MANT_OVF:  begin f.exp = eb; f.mant = {8'hFF, r[14:0]}; end
        MODE_SCALE_OVF: begin f.exp = EXP_MAX; f.mant = '1; end
        MODE_NAN:       if (first && k == nan_lane) begin
                          f.exp  = NAN_EXP;
                          f.mant = {1'b1, r[21:0]};
                        end
        MODE_SUBNORM:   begin f.exp = '0; f.mant = r[22:0] | 23'h1; end
        MODE_ZERO:      begin f.exp = '0; f.mant = '0; end
        default:        ;
      endcase
      w[FLOAT32_WIDTH*k +: FLOAT32_WIDTH] = f;
    end
    return w;
  endfunction

  mx_stim_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_c),
    .adv_i  (accept_c),
    .lfsr_o (lfsr_q)
  );

  assign lfsr_nxt = lfsr_step(lfsr_q);
  assign accept_c = valid_q & ready_i;
  assign load_c   = (state_q == ST_IDLE) & start_i;

  // Lowest enabled mode at or above the cursor; cursor 8 means the sweep is finished.
  always_comb begin
    sel_found_c = 1'b0;
    sel_mode_c  = MODE_NORMAL;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (4'(i) >= cur_q)) begin
        sel_found_c = 1'b1;
        sel_mode_c  = mode_e'(3'(i));
      end
    end
  end

  always_comb begin
    last_beat_c = (beat_q == BEAT_W'(BEATS - 1));
    last_blk_c  = (blk_q == BLK_W'(BLOCKS_PER_MODE - 1));
    beat_n_c    = last_beat_c ? '0 : beat_q + BEAT_W'(1);
    blk_n_c     = last_beat_c ? blk_q + BLK_W'(1) : blk_q;
    eb_n_c      = last_beat_c ? block_exp(lfsr_nxt[30:23]) : eb_q;
    data_n_c    = beat_word(lfsr_nxt, mode_q, blk_n_c[0], last_beat_c, eb_n_c);
    first_c     = beat_word(lfsr_q, sel_mode_c, 1'b0, 1'b1, block_exp(lfsr_q[30:23]));
  end

`ifdef MX_STIM_CHECKSUM_EN
  logic [31:0] csum_q;

  function automatic logic [31:0] lane_xor(input logic [DATA_W-1:0] d);
    logic [31:0] x;
    x = '0;
    for (int k = 0; k < int'(LANES); k++) x = x ^ d[FLOAT32_WIDTH*k +: FLOAT32_WIDTH];
    return x;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               csum_q <= '0;
    else if (load_c)                       csum_q <= '0;
    else if (accept_c)                     csum_q <= csum_q ^ lane_xor(data_q);
  end

  assign checksum_o = csum_q;
`endif

  // Mode sweep FSM; the next beat is preloaded on acceptance so outputs hold during back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_NORMAL;
      mask_q  <= '0;
      cur_q   <= '0;
      beat_q  <= '0;
      blk_q   <= '0;
      eb_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start_i) begin
          mask_q  <= mode_mask_i;
          cur_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= ST_SEL;
        end
        ST_SEL: if (sel_found_c) begin
          mode_q  <= sel_mode_c;
          beat_q  <= '0;
          blk_q   <= '0;
          eb_q    <= block_exp(lfsr_q[30:23]);
          data_q  <= first_c;
          last_q  <= (BEATS == 1);
          valid_q <= 1'b1;
          state_q <= ST_GEN;
        end else begin
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_GEN: if (accept_c) begin
          if (last_beat_c && last_blk_c) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cur_q   <= {1'b0, mode_q} + 4'd1;
            state_q <= ST_SEL;
          end else begin
            beat_q  <= beat_n_c;
            blk_q   <= blk_n_c;
            eb_q    <= eb_n_c;
            data_q  <= data_n_c;
            last_q  <= (beat_n_c == BEAT_W'(BEATS - 1));
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign mode_o  = mode_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_mx_fp32_stim_gen.sv
// Self-checking bench for mx_fp32_stim_gen: spec-level stream model plus hand-computed literal vectors.
module tb_mx_fp32_stim_gen;

  localparam int LANES = 4;
  localparam int BLOCK_SIZE = 32;
  localparam int BPM = 3;
  localparam int BEATS = BLOCK_SIZE / LANES;
  localparam int DW = 32 * LANES;
  localparam logic [31:0] SEED = 32'hACE12468;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [2:0]    mode;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, start_i, ready_i;
  logic [7:0]    mode_mask_i;
  logic          valid_o, last_o, busy_o, done_o;
  logic [DW-1:0] data_o;
  logic [2:0]    mode_o;
`ifdef MX_STIM_CHECKSUM_EN
  logic [31:0]   checksum_o;
`endif

  int            vectors = 0;
  int            miscompares = 0;
  beat_t         exp_q[$];
  logic [DW-1:0] seen[$];
  logic [DW-1:0] ref_q[$];
  int            last_cnt;
  logic [31:0]   exp_csum;

  mx_fp32_stim_gen #(
    .LANES(LANES), .BLOCK_SIZE(BLOCK_SIZE), .BLOCKS_PER_MODE(BPM), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_mask_i(mode_mask_i), .ready_i(ready_i),
    .valid_o(valid_o), .data_o(data_o), .last_o(last_o), .mode_o(mode_o),
    .busy_o(busy_o), .done_o(done_o)
`ifdef MX_STIM_CHECKSUM_EN
    , .checksum_o(checksum_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_adv(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
  endfunction

  function automatic logic [31:0] rot(input logic [31:0] x, input int s);
    logic [63:0] d;
    d = {x, x} << (s % 32);
    return d[63:32];
  endfunction

  // Element rules written directly from the mode table.
  function automatic logic [31:0] model_word(input logic [31:0] st, input int m, input int b,
                                             input int bt, input int k, input logic [7:0] eb);
    logic [31:0] r;
    logic [7:0]  e;
    logic [22:0] mt;
    r  = rot(st, 5 * k);
    e  = r[30:23];
    if (e == 8'd0) e = 8'd1;
    else if (e == 8'd255) e = 8'd254;
    mt = r[22:0];
    case (m)
      1: mt = (r[22:0] & 23'h007FFF) | 23'h7F8000;
      2: mt = (r[22:0] & 23'h7F0000) | 23'h008000;
      3: begin e = eb; mt = (r[22:0] & 23'h007FFF) | 23'h7F8000; end
      4: begin e = 8'hFE; mt = 23'h7FFFFF; end
      5: if (bt == 0 && k == int'(st[1:0]) % LANES) begin
           e  = 8'hFF;
           mt = 23'h400000 | (r[22:0] & 23'h3FFFFF);
         end
      6: begin e = 8'h00; mt = r[22:0] | 23'h1; end
      7: begin e = 8'h00; mt = 23'h0; end
      default: ;
    endcase
    return {(b % 2 == 1), e, mt};
  endfunction

  task automatic build(input logic [7:0] mask);
    logic [31:0] st;
    logic [7:0]  eb;
    beat_t       e;
    st = SEED;
    exp_q.delete();
    exp_csum = '0;
    for (int m = 0; m < 8; m++) begin
      if (mask[m]) begin
        for (int b = 0; b < BPM; b++) begin
          eb = (st[30:23] == 8'd0) ? 8'd1 : ((st[30:23] > 8'd253) ? 8'd253 : st[30:23]);
          for (int bt = 0; bt < BEATS; bt++) begin
            e.data = '0;
            for (int k = 0; k < LANES; k++) begin
              e.data[32*k +: 32] = model_word(st, m, b, bt, k, eb);
              exp_csum = exp_csum ^ e.data[32*k +: 32];
            end
            e.last = (bt == BEATS - 1);
            e.mode = 3'(m);
            exp_q.push_back(e);
            st = lfsr_adv(st);
          end
        end
      end
    end
  endtask

  // Compare every presented beat against the model head; pop only on acceptance.
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: valid_o=1 data %h, model has no beat pending", data_o);
      end else begin
        chk("data", data_o, exp_q[0].data);
        chk("last", DW'(last_o), DW'(exp_q[0].last));
        chk("mode", DW'(mode_o), DW'(exp_q[0].mode));
        if (ready_i) begin
          seen.push_back(data_o);
          if (last_o) last_cnt++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // rmode: 0 ready always, 1 ready low for five cycles mid-block, 2 random ready.
  task automatic run(input logic [7:0] mask, input int rmode, input bit poke);
    int n, cyc;
    bit got;
    build(mask);
    seen.delete();
    last_cnt = 0;
    n = $countones(mask);
    @(posedge clk); #1;
    start_i = 1'b1;
    mode_mask_i = mask;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("sel_valid_low", DW'(valid_o), DW'(0));
    chk("busy_after_start", DW'(busy_o), DW'(1));
    cyc = 0;
    got = 1'b0;
    while (cyc < 3000 && !got) begin
      if (rmode == 0)      ready_i = 1'b1;
      else if (rmode == 1) ready_i = !(cyc >= 5 && cyc < 10);
      else                 ready_i = 1'($urandom_range(0, 1));
      if (poke) begin
        start_i = (cyc == 10);
        mode_mask_i = (cyc >= 10) ? 8'hFF : mask;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk("first_valid_latency", DW'(valid_o), DW'(n > 0));
      if (done_o) got = 1'b1;
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    chk("done_seen", DW'(got), DW'(1));
    if (rmode == 0) chk("done_cycle", DW'(cyc), DW'(25 * n + 1));
    chk("queue_drained", DW'(exp_q.size()), DW'(0));
    chk("beat_count", DW'(seen.size()), DW'(BEATS * BPM * n));
    chk("last_count", DW'(last_cnt), DW'(BPM * n));
`ifdef MX_STIM_CHECKSUM_EN
    chk("checksum", DW'(checksum_o), DW'(exp_csum));
`endif
    @(posedge clk); #1;
    chk("done_one_cycle", DW'(done_o), DW'(0));
    chk("busy_cleared", DW'(busy_o), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [31:0]   s;
    int            bad;
    rst = 1'b1;
    start_i = 1'b0;
    ready_i = 1'b1;
    mode_mask_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", DW'(valid_o), DW'(0));
    chk("rst_busy", DW'(busy_o), DW'(0));
    chk("rst_done", DW'(done_o), DW'(0));
    chk("rst_last", DW'(last_o), DW'(0));
    chk("rst_mode", DW'(mode_o), DW'(0));
    chk("rst_data", data_o, DW'(0));
    rst = 1'b0;

    s = SEED;
    for (int i = 0; i < 4; i++) s = lfsr_adv(s);
    chk("model_lfsr_pin", DW'(s), DW'(32'h8AEE1245));

    run(8'h80, 0, 0);
    w = seen[0];  chk("zero_blk0", w, {LANES{32'h00000000}});
    w = seen[8];  chk("zero_blk1", w, {LANES{32'h80000000}});
    w = seen[23]; chk("zero_blk2", w, {LANES{32'h00000000}});

    run(8'h10, 0, 0);
    w = seen[0];  chk("sovf_blk0", w, {LANES{32'h7F7FFFFF}});
    w = seen[15]; chk("sovf_blk1", w, {LANES{32'hFF7FFFFF}});
    w = seen[16]; chk("sovf_blk2", w, {LANES{32'h7F7FFFFF}});

    run(8'h04, 0, 0);
    bad = 0;
    foreach (seen[i]) begin
      w = seen[i];
      for (int k = 0; k < LANES; k++) begin
        s = w[32*k +: 32];
        if (s[15:0] != 16'h8000 || s[30:23] == 8'h00 || s[30:23] == 8'hFF) bad++;
      end
    end
    chk("tie_words", DW'(bad), DW'(0));

    run(8'h01, 0, 0);
    w = seen[0];
    chk("normal_b0_l0", DW'(w[31:0]), DW'(32'h2CE12468));
    chk("normal_b0_l1", DW'(w[63:32]), DW'(32'h1C248D15));
    w = seen[4];
    chk("normal_b4_l0", DW'(w[31:0]), DW'(32'h0AEE1245));
    ref_q = seen;

    run(8'h01, 1, 0);
    bad = (seen.size() == ref_q.size()) ? 0 : 1;
    foreach (ref_q[i]) if (i < seen.size() && seen[i] !== ref_q[i]) bad++;
    chk("stall_same_stream", DW'(bad), DW'(0));

    run(8'h80, 0, 1);
    run(8'h00, 0, 0);
    run(8'h6A, 2, 0);

    build(8'hFF);
    @(posedge clk); #1;
    start_i = 1'b1;
    mode_mask_i = 8'hFF;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_valid", DW'(valid_o), DW'(0));
    chk("midrst_busy", DW'(busy_o), DW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    run(8'hFF, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
